// File: rtl/demux2_stream_pkg.sv
// Shared constants for the 2-way stream demultiplexer.
//   FIFO_DEPTH   : entries per output FIFO
//   CNT_W        : width of the per-port transfer counters
//   DEF_BITWIDTH : default data path width
//   OCC_W        : width of a FIFO occupancy value (0..FIFO_DEPTH)
package demux2_stream_pkg;

   localparam int unsigned FIFO_DEPTH   = 2;
   localparam int unsigned CNT_W        = 8;
   localparam int unsigned DEF_BITWIDTH = 32;
   localparam int unsigned OCC_W        = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/fifo2.sv
// Two-entry FIFO with a valid/ready output port and a transfer counter.
//   clk, rst_n : clock, async active-low reset
//   push_req   : request to push push_data (ignored while full)
//   push_data  : word to push
//   full       : registered full flag
//   valid      : registered not-empty flag
//   ready      : downstream takes the head word
//   data       : registered head word (holds its last value when empty)
//   cnt        : count of completed output transfers, wraps
module fifo2
   import demux2_stream_pkg::*;
#(
   parameter int unsigned bitwidth = DEF_BITWIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push_req,
   input  logic [bitwidth-1:0] push_data,
   output logic                full,
   output logic                valid,
   input  logic                ready,
   output logic [bitwidth-1:0] data,
   output logic [CNT_W-1:0]    cnt
);

   logic [OCC_W-1:0]    occ_q;
   logic [OCC_W-1:0]    occ_d;
   logic [bitwidth-1:0] head_d;
   logic [bitwidth-1:0] tail_q;
   logic [bitwidth-1:0] tail_d;
   logic                push;
   logic                pop;

   // Next-state: head lives in 'data' so the output is a plain register.
   // A full FIFO refuses pushes even when popped in the same cycle.
   always_comb begin
      push   = push_req & ~full;
      pop    = valid & ready;
      occ_d  = occ_q;
      head_d = data;
      tail_d = tail_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == OCC_W'(0)) head_d = push_data;
            else                    tail_d = push_data;
            occ_d = occ_q + OCC_W'(1);
         end
         2'b01: begin
            if (occ_q == OCC_W'(FIFO_DEPTH)) head_d = tail_q;
            occ_d = occ_q - OCC_W'(1);
         end
         // push and pop together only happens at occupancy 1
         2'b11: head_d = push_data;
         default: ;
      endcase
   end

   // State and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q  <= '0;
         data   <= '0;
         tail_q <= '0;
         valid  <= 1'b0;
         full   <= 1'b0;
         cnt    <= '0;
      end else begin
         occ_q  <= occ_d;
         data   <= head_d;
         tail_q <= tail_d;
         valid  <= (occ_d != OCC_W'(0));
         full   <= (occ_d == OCC_W'(FIFO_DEPTH));
         if (pop) cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/demux2_stream.sv
// Routes a valid/ready input stream to one of two output streams by sel,
// each output buffered by a 2-entry FIFO.
//   clk, rst_n                 : clock, async active-low reset
//   sel                        : 0 -> port a, 1 -> port b
//   in_valid/in_ready/in_data  : input stream
//   a_valid/a_ready/a_data     : output stream a
//   b_valid/b_ready/b_data     : output stream b
//   a_cnt, b_cnt               : completed transfers per output port
module demux2_stream
   import demux2_stream_pkg::*;
#(
   parameter int unsigned bitwidth = DEF_BITWIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sel,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [bitwidth-1:0] in_data,
   output logic                a_valid,
   input  logic                a_ready,
   output logic [bitwidth-1:0] a_data,
   output logic                b_valid,
   input  logic                b_ready,
   output logic [bitwidth-1:0] b_data,
   output logic [CNT_W-1:0]    a_cnt,
   output logic [CNT_W-1:0]    b_cnt
);

   logic a_full;
   logic b_full;

   // Depends only on sel and registered full flags, never on downstream ready
   assign in_ready = sel ? ~b_full : ~a_full;

   fifo2 #(.bitwidth(bitwidth)) u_fifo_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_req  (in_valid & ~sel),
      .push_data (in_data),
      .full      (a_full),
      .valid     (a_valid),
      .ready     (a_ready),
      .data      (a_data),
      .cnt       (a_cnt)
   );

   fifo2 #(.bitwidth(bitwidth)) u_fifo_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_req  (in_valid & sel),
      .push_data (in_data),
      .full      (b_full),
      .valid     (b_valid),
      .ready     (b_ready),
      .data      (b_data),
      .cnt       (b_cnt)
   );

endmodule

// File: tb/tb_demux2_stream.sv
// Self-checking bench for demux2_stream: directed vectors plus a random
// scoreboard run.
module tb_demux2_stream;

   logic        clk;
   logic        rst_n;
   logic        sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        a_valid;
   logic        a_ready;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [31:0] b_data;
   logic [7:0]  a_cnt;
   logic [7:0]  b_cnt;

   int n_total = 0;
   int n_pass  = 0;

   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic [7:0]  ca;
   logic [7:0]  cb;

   demux2_stream #(.bitwidth(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel      (sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_data   (b_data),
      .a_cnt    (a_cnt),
      .b_cnt    (b_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [31:0] d);
      in_valid = v;
      sel      = s;
      in_data  = d;
      #1;
   endtask

   initial begin
      logic iv, s, ar, br, pa, pb;
      logic [31:0] d;

      rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; in_data = '0;
      a_ready = 1'b0; b_ready = 1'b0;
      #2;
      check("rst_a_valid", a_valid, 0);
      check("rst_b_valid", b_valid, 0);
      check("rst_a_data",  a_data,  0);
      check("rst_b_data",  b_data,  0);
      check("rst_a_cnt",   a_cnt,   0);
      check("rst_b_cnt",   b_cnt,   0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk); #1; rst_n = 1'b1;

      // Routing
      a_ready = 1'b1; b_ready = 1'b1;
      drive(1'b1, 1'b0, 32'h11111111); check("route_rdy_a", in_ready, 1);
      cyc();
      check("route_a_valid", a_valid, 1);
      check("route_a_data",  a_data, 32'h11111111);
      check("route_b_idle",  b_valid, 0);
      drive(1'b1, 1'b1, 32'h22222222); check("route_rdy_b", in_ready, 1);
      cyc();
      check("route_b_valid", b_valid, 1);
      check("route_b_data",  b_data, 32'h22222222);
      check("route_a_drained", a_valid, 0);
      check("route_a_cnt", a_cnt, 1);
      drive(1'b0, 1'b0, '0); cyc();
      check("route_b_drained", b_valid, 0);
      check("route_b_cnt", b_cnt, 1);

      // Full / backpressure on a, b still accepted
      a_ready = 1'b0;
      drive(1'b1, 1'b0, 32'hAAAA0001); check("full_rdy1", in_ready, 1); cyc();
      drive(1'b1, 1'b0, 32'hAAAA0002); check("full_rdy2", in_ready, 1); cyc();
      drive(1'b1, 1'b0, 32'hAAAA0003); check("full_rdy3", in_ready, 0); cyc();
      check("full_a_valid", a_valid, 1);
      check("full_a_head", a_data, 32'hAAAA0001);
      drive(1'b1, 1'b1, 32'hBBBB0001); check("cross_rdy", in_ready, 1); cyc();
      check("cross_b_valid", b_valid, 1);
      check("cross_b_data", b_data, 32'hBBBB0001);
      // Full FIFO refuses push even while being popped
      a_ready = 1'b1;
      drive(1'b1, 1'b0, 32'hAAAA0003); check("full_pop_rdy", in_ready, 0); cyc();
      check("full_pop_head", a_data, 32'hAAAA0002);
      check("cross_b_cnt", b_cnt, 2);

      // Simultaneous push/pop at occupancy 1
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, 32'hA0 + 32'(k)); check("simul_rdy", in_ready, 1);
         cyc();
         check("simul_valid", a_valid, 1);
         check("simul_data", a_data, 32'hA0 + 32'(k));
      end
      drive(1'b0, 1'b0, '0); cyc();
      check("simul_drained", a_valid, 0);
      check("simul_a_cnt", a_cnt, 7);

      // Counter wrap on b (b_cnt starts at 2)
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 1'b1, 32'(i)); cyc();
         check("wrap_b_data", b_data, 32'(i));
         if (i == 253) check("wrap_b_cnt_255", b_cnt, 255);
         if (i == 254) check("wrap_b_cnt_0", b_cnt, 0);
      end
      drive(1'b0, 1'b0, '0); cyc();
      check("wrap_b_cnt_end", b_cnt, 2);
      check("wrap_a_cnt", a_cnt, 7);
      check("wrap_b_drained", b_valid, 0);

      // Async reset with both FIFOs full
      a_ready = 1'b0; b_ready = 1'b0;
      drive(1'b1, 1'b0, 32'hC0C0C0C0); cyc();
      drive(1'b1, 1'b0, 32'hC1C1C1C1); cyc();
      drive(1'b1, 1'b1, 32'hD0D0D0D0); cyc();
      drive(1'b1, 1'b1, 32'hD1D1D1D1); cyc();
      drive(1'b0, 1'b0, '0);
      check("pre_rst_a_full", in_ready, 0);
      check("pre_rst_b_valid", b_valid, 1);
      #1; rst_n = 1'b0; #1;
      check("arst_a_valid", a_valid, 0);
      check("arst_b_valid", b_valid, 0);
      check("arst_a_data",  a_data, 0);
      check("arst_b_data",  b_data, 0);
      check("arst_a_cnt",   a_cnt, 0);
      check("arst_b_cnt",   b_cnt, 0);
      check("arst_in_ready", in_ready, 1);
      @(posedge clk); #1; rst_n = 1'b1;
      a_ready = 1'b1; b_ready = 1'b1;
      drive(1'b1, 1'b0, 32'h55555555); cyc();
      check("post_rst_a_data", a_data, 32'h55555555);
      check("post_rst_a_valid", a_valid, 1);
      check("post_rst_b_stale", b_valid, 0);
      drive(1'b0, 1'b0, '0); cyc();
      check("post_rst_a_stale", a_valid, 0);
      check("post_rst_a_cnt", a_cnt, 1);
      check("post_rst_b_cnt", b_cnt, 0);

      // Random traffic against a queue scoreboard
      #1; rst_n = 1'b0; #1; rst_n = 1'b1;
      ca = '0; cb = '0;
      cyc();
      for (int c = 0; c < 10000; c++) begin
         check("rnd_a_valid", a_valid, 32'(qa.size() != 0));
         check("rnd_b_valid", b_valid, 32'(qb.size() != 0));
         if (qa.size() != 0) check("rnd_a_data", a_data, qa[0]);
         if (qb.size() != 0) check("rnd_b_data", b_data, qb[0]);
         check("rnd_a_cnt", a_cnt, 32'(ca));
         check("rnd_b_cnt", b_cnt, 32'(cb));
         iv = 1'($urandom_range(0, 1));
         s  = 1'($urandom_range(0, 1));
         d  = $urandom;
         ar = ($urandom_range(0, 2) != 0);
         br = ($urandom_range(0, 2) != 0);
         a_ready = ar; b_ready = br;
         drive(iv, s, d);
         check("rnd_in_ready", in_ready, 32'(s ? (qb.size() < 2) : (qa.size() < 2)));
         pa = (qa.size() != 0) && ar;
         pb = (qb.size() != 0) && br;
         if (iv && !s && qa.size() < 2) begin
            if (pa) void'(qa.pop_front());
            qa.push_back(d);
         end else if (pa) void'(qa.pop_front());
         if (iv && s && qb.size() < 2) begin
            if (pb) void'(qb.pop_front());
            qb.push_back(d);
         end else if (pb) void'(qb.pop_front());
         if (pa) ca = ca + 8'd1;
         if (pb) cb = cb + 8'd1;
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/demux2_stream.md
DEMUX2_STREAM -- requirements
Module: demux2_stream

Interface
REQ-001 Parameter: bitwidth, default 32, data path width.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: sel  input  1  destination of the offered word: 0 routes to port a, 1 routes to port b.
REQ-005 Port: in_valid  input  1  upstream offers a word.
REQ-006 Port: in_ready  output  1  block accepts the offered word.
REQ-007 Port: in_data  input  bitwidth  offered word.
REQ-008 Port: a_valid / b_valid  output  1 each  port a/b presents a word.
REQ-009 Port: a_ready / b_ready  input  1 each  downstream a/b takes the word.
REQ-010 Port: a_data / b_data  output  bitwidth each  presented word.
REQ-011 Port: a_cnt / b_cnt  output  8 each  count of completed output transfers on a/b.

Function
REQ-012 The block SHALL use a handshake transfer rule on every port: a transfer occurs on a rising clk edge where valid and ready are both 1.
REQ-013 The block SHALL contain one 2-entry FIFO per output port.
REQ-014 in_ready SHALL be 1 when the FIFO selected by sel is not full. in_ready SHALL depend only on sel and the registered FIFO state, never on a_ready or b_ready.
REQ-015 An input transfer SHALL push in_data into FIFO a when sel=0 and into FIFO b when sel=1. sel is sampled in the same cycle as in_data.
REQ-016 a_valid and a_data SHALL be driven from registered FIFO a state: a_valid = FIFO a not empty, a_data = FIFO a head. Port b SHALL behave identically with FIFO b.
REQ-017 A word accepted at edge N SHALL be visible on its output port from edge N onward, giving 1-cycle latency. There SHALL be no combinational path from input to output.
REQ-018 Each FIFO SHALL deliver words in acceptance order.
REQ-019 A full FIFO SHALL refuse a push even if it is popped in the same cycle.
REQ-020 A FIFO with 1 entry SHALL support a simultaneous push and pop, keeping occupancy at 1 with the new word at the head.
REQ-021 When a FIFO is empty, its valid output SHALL be 0 and its data output SHALL hold its last value. The data output SHALL NOT be checked while valid is 0.
REQ-022 A stall on one port SHALL NOT block traffic routed to the other port.
REQ-023 While valid is 1 and ready is 0, the presented data SHALL stay stable.
REQ-024 a_cnt SHALL increment by 1 on each port a output transfer and wrap from 255 to 0. b_cnt SHALL behave the same for port b.
REQ-025 When in_valid=0, sel SHALL be ignored and nothing SHALL be pushed.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, empty both FIFOs and clear all pointers. It SHALL drive a_valid=0, b_valid=0, a_data=0, b_data=0, a_cnt=0 and b_cnt=0. in_ready SHALL then reflect two empty FIFOs (1).
REQ-027 Reset asserted mid-transfer SHALL discard all queued words.
REQ-028 The first transfer after reset SHALL be possible at the first rising clk edge after rst_n deasserts.

Structure
REQ-029 A shared package SHALL hold the FIFO depth (2), the counter width (8) and the default bitwidth (32).
REQ-030 The 2-entry FIFO SHALL be a sub-module named fifo2, parameterised by bitwidth and instantiated twice.
REQ-031 The implementation SHALL fall within 120-400 lines of RTL.

Verification
REQ-032 Routing: after reset, push 0x11111111 with sel=0 and 0x22222222 with sel=1, with a_ready=b_ready=1. Required: a_data=0x11111111 with a_valid one cycle after acceptance, and b_data=0x22222222 likewise. Required: a_cnt=1 and b_cnt=1.
REQ-033 Full/backpressure: with a_ready=0, push 3 words with sel=0. Required: the first two are accepted and in_ready=0 on the third. A word offered with sel=1 in that state is still accepted.
REQ-034 Order and simultaneity: with FIFO a holding 1 entry and a_ready=1, push 0xA each cycle. Required: occupancy stays at 1 and the output sequence matches the input order exactly.
REQ-035 Counter wrap: complete 256 transfers on port b. Required: b_cnt reads 255 then 0, and a_cnt is unchanged.
REQ-036 Async reset: assert rst_n=0 between clock edges with both FIFOs full. Required: valids, data outputs and counters are 0 before the next edge, and no stale word appears after release.
REQ-037 Random: random sel, valid and ready over 10000 cycles against a scoreboard. Required: no loss, no duplication, order preserved per port, and data held stable while stalled.
